sprite_fetch: RTL

- Read-side client of the sprite ROM and palette ROM.
- Per VGA pixel it does four things:
  - hit-tests DrawX/DrawY against one sprite's screen box;
  - generates the sprite ROM read address, including the animation frame offset;
  - forwards the returned 4-bit colour index to the palette;
  - emits a pipeline-aligned 24-bit RGB pixel with transparency.
- Sits between the VGA controller and the colour mapper. One instance per sprite type (alien, ship).

---
 rtl/sprite_pkg.sv | 12 +
 rtl/sprite_anim_ctr.sv | 45 ++++
 rtl/sprite_fetch.sv | 80 ++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and default geometry for the sprite fetch pipeline.
package sprite_pkg;
  typedef logic [9:0]  coord_t;
  typedef logic [23:0] rgb_t;
  typedef logic [3:0]  pidx_t;
  typedef enum logic {ANIM_DISABLED, ANIM_RUN} anim_state_t;
  localparam int SPR_W       = 24;
  localparam int SPR_H       = 14;
  localparam int FRAMES      = 2;
  localparam int TRANSP_IDX  = 0;
  localparam int SPR_LATENCY = 4;
endpackage

// File: rtl/sprite_anim_ctr.sv
// sprite_anim_ctr: frame_tick divider and animation frame selector.
module sprite_anim_ctr import sprite_pkg::*; #(
  parameter int FRAMES   = sprite_pkg::FRAMES,
  parameter int ANIM_DIV = 30
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_tick,
  output logic [$clog2(FRAMES)-1:0] o_frame
);
  localparam int DW = $clog2(ANIM_DIV);
  localparam int FW = $clog2(FRAMES);
  anim_state_t r_state, w_state_n;
  logic [DW-1:0] r_div, w_div_base, w_div_n;
  logic [FW-1:0] r_frame, w_frame_base, w_frame_n;
  logic          w_wrap;
  // Counting starts from zero when entering RUN, so a tick on the enabling edge counts.
  always_comb begin
    w_state_n    = i_en ? ANIM_RUN : ANIM_DISABLED;
    w_div_base   = (r_state == ANIM_RUN) ? r_div : '0;
    w_frame_base = (r_state == ANIM_RUN) ? r_frame : '0;
    w_wrap       = w_div_base == DW'(ANIM_DIV - 1);
    w_div_n      = w_div_base;
    w_frame_n    = w_frame_base;
    if (!i_en) begin
      w_div_n   = '0;
      w_frame_n = '0;
    end else if (i_tick) begin
      w_div_n   = w_wrap ? '0 : w_div_base + DW'(1);
      w_frame_n = !w_wrap ? w_frame_base : (w_frame_base == FW'(FRAMES - 1)) ? '0 : w_frame_base + FW'(1);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= ANIM_DISABLED;
      r_div   <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_n;
      r_div   <= w_div_n;
      r_frame <= w_frame_n;
    end
  assign o_frame = r_frame;
endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: sprite hit test, ROM address generation and 4-edge colour pipeline.
// Define SPRITE_MIRROR_EN to add the mirror_x horizontal flip input.
module sprite_fetch import sprite_pkg::*; #(
  parameter int SPR_W      = sprite_pkg::SPR_W,
  parameter int SPR_H      = sprite_pkg::SPR_H,
  parameter int FRAMES     = sprite_pkg::FRAMES,
  parameter int ADDR_W     = 10,
  parameter int TRANSP_IDX = sprite_pkg::TRANSP_IDX,
  parameter int ANIM_DIV   = 30
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  coord_t                    DrawX,
  input  coord_t                    DrawY,
  input  logic                      pix_valid,
  input  coord_t                    spr_x,
  input  coord_t                    spr_y,
  input  logic                      spr_en,
  input  logic                      frame_tick,
`ifdef SPRITE_MIRROR_EN
  input  logic                      mirror_x,
`endif
  output logic [ADDR_W-1:0]         rom_addr,
  input  pidx_t                     rom_data,
  output pidx_t                     pal_addr,
  input  rgb_t                      pal_data,
  output rgb_t                      rgb,
  output logic                      opaque,
  output logic [$clog2(FRAMES)-1:0] frame_sel
);
  logic [10:0]       w_x_end, w_y_end;
  logic              w_hit;
  coord_t            w_dx, w_dy, w_col;
  logic [ADDR_W-1:0] w_addr, r_rom_addr;
  logic              r_hit1, r_hit2, r_hit3, r_opaque;
  pidx_t             r_idx3;
  rgb_t              r_rgb;
  sprite_anim_ctr #(.FRAMES(FRAMES), .ANIM_DIV(ANIM_DIV)) u_anim (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_en    (spr_en),
    .i_tick  (frame_tick),
    .o_frame (frame_sel)
  );
  // Box ends are 11 bits wide so a sprite near column 1023 cannot wrap to the left edge.
  assign w_x_end = {1'b0, spr_x} + 11'(SPR_W);
  assign w_y_end = {1'b0, spr_y} + 11'(SPR_H);
  assign w_hit   = pix_valid & spr_en & (DrawX >= spr_x) & ({1'b0, DrawX} < w_x_end)
                 & (DrawY >= spr_y) & ({1'b0, DrawY} < w_y_end);
  assign w_dx    = DrawX - spr_x;
  assign w_dy    = DrawY - spr_y;
`ifdef SPRITE_MIRROR_EN
  assign w_col   = mirror_x ? coord_t'(SPR_W - 1) - w_dx : w_dx;
`else
  assign w_col   = w_dx;
`endif
  assign w_addr  = ADDR_W'(frame_sel) * ADDR_W'(SPR_W * SPR_H) + ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_col);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_hit1     <= 1'b0;
      r_hit2     <= 1'b0;
      r_hit3     <= 1'b0;
      r_idx3     <= '0;
      r_rgb      <= '0;
      r_opaque   <= 1'b0;
    end else begin
      if (w_hit) r_rom_addr <= w_addr;
      r_hit1   <= w_hit;
      r_hit2   <= r_hit1;
      r_hit3   <= r_hit2;
      r_idx3   <= rom_data;
      r_rgb    <= r_hit3 ? pal_data : '0;
      r_opaque <= r_hit3 & (r_idx3 != pidx_t'(TRANSP_IDX));
    end
  assign rom_addr = r_rom_addr;
  assign pal_addr = rom_data;
  assign rgb      = r_rgb;
  assign opaque   = r_opaque;
endmodule
